// File: rtl/data_mem_pkg.sv
// Shared definitions for the sized data memory.
// Provides access-size encodings, FSM state encodings and a helper that
// maps an access size to the number of bytes it touches.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Bytes covered by an access; the reserved size reports 4 so the
  // range check stays conservative (it is flagged as an error anyway).
  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the sized data memory.
// Ports:
//   size_i      access size (byte/half/word/reserved)
//   unsigned_i  1 = zero-extend loads, 0 = sign-extend
//   off_i       byte offset within the addressed 32-bit word
//   rword_i     raw 32-bit memory word containing the access
//   be_o        per-byte write enables for stores
//   misalign_o  half not on an even address, or word not on a multiple of 4
//   rdata_o     extracted and extended load result
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted_s;
  logic        ext_s;

  // Decode byte enables, alignment and the load result for the access size.
  always_comb begin
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    rdata_o    = 32'h0000_0000;
    ext_s      = 1'b0;
    // Move the addressed lane(s) down to bit 0 before extending.
    shifted_s  = rword_i >> {off_i, 3'b000};
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << off_i;
        ext_s   = ~unsigned_i & shifted_s[7];
        rdata_o = {{24{ext_s}}, shifted_s[7:0]};
      end
      SZ_HALF: begin
        be_o       = 4'b0011 << off_i;
        misalign_o = off_i[0];
        ext_s      = ~unsigned_i & shifted_s[15];
        rdata_o    = {{16{ext_s}}, shifted_s[15:0]};
      end
      SZ_WORD: begin
        be_o       = 4'b1111;
        misalign_o = (off_i != 2'b00);
        rdata_o    = rword_i;
      end
      default: begin
        be_o       = 4'b0000;
        misalign_o = 1'b0;
        rdata_o    = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed little-endian data memory for the MEM stage with a
// req/ready/valid handshake and a fixed access latency.
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   req_i / ready_o    request strobe; accepted when both high at a rising edge
//   we_i               1 = store, 0 = load
//   size_i             00 byte, 01 half, 10 word, 11 reserved
//   unsigned_i         zero-extend (1) or sign-extend (0) loads
//   addr_i, data_i     byte address and store data
//   valid_o            one-cycle completion pulse
//   err_o              misaligned / out-of-range / reserved-size flag, with valid_o
//   data_o             load result, held until the next load or error completion
module data_mem_sized
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LATENCY     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              ready_o,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              valid_o,
  output logic              err_o,
  output logic [31:0]       data_o
);

  localparam int unsigned IDX_W   = $clog2(DEPTH_BYTES);
  localparam int unsigned WORDS   = DEPTH_BYTES / 4;
  localparam int unsigned WIDX_W  = (IDX_W > 2) ? IDX_W - 2 : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  // Storage is organised as 32-bit words so one lane-steered read serves
  // every aligned access; the memory itself is never cleared.
  logic [31:0] mem_q [WORDS];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              uns_q;
  logic              valid_q;
  logic              err_q;
  logic [31:0]       data_q;

  logic              ready_s;
  logic              accept_s;
  logic              access_s;
  logic [WIDX_W-1:0] word_idx_s;
  logic [3:0]        be_s;
  logic              misalign_s;
  logic [31:0]       rdata_s;
  logic [31:0]       wlane_s;
  logic [ADDR_W:0]   limit_s;
  logic              oor_s;
  logic              err_s;

  if (IDX_W > 2) begin : g_widx
    assign word_idx_s = addr_q[IDX_W-1:2];
  end else begin : g_widx_single
    assign word_idx_s = 1'b0;
  end

  mem_lane_align u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (addr_q[1:0]),
    .rword_i    (mem_q[word_idx_s]),
    .be_o       (be_s),
    .misalign_o (misalign_s),
    .rdata_o    (rdata_s)
  );

  // Compare one bit wider than the address so a top-of-range address that
  // would wrap when adding the access size is still caught.
  assign limit_s  = (ADDR_W+1)'(DEPTH_BYTES) - (ADDR_W+1)'(access_bytes(size_q));
  assign oor_s    = ({1'b0, addr_q} > limit_s);
  assign err_s    = misalign_s | oor_s | (size_q == SZ_RSVD);
  assign wlane_s  = wdata_q << {addr_q[1:0], 3'b000};

  assign accept_s = req_i & ready_s;
  assign access_s = (state_q == BUSY) && (cnt_q == 4'd0);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE on accept, return when the counter expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i) state_d = BUSY;
        else       state_d = IDLE;
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: ready only while idle.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      IDLE:    ready_s = 1'b1;
      BUSY:    ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  // Request capture, latency counter and registered completion outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 32'h0000_0000;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (accept_s) begin
        addr_q  <= addr_i;
        wdata_q <= data_i;
        size_q  <= size_i;
        we_q    <= we_i;
        uns_q   <= unsigned_i;
        cnt_q   <= CNT_INIT;
      end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access_s) begin
        valid_q <= 1'b1;
        err_q   <= err_s;
        // Errors clear the result; stores leave the last load result alone.
        if (err_s)      data_q <= 32'h0000_0000;
        else if (!we_q) data_q <= rdata_s;
      end
    end
  end

  // Byte-lane store commit; reset on the access edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && access_s && we_q && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) mem_q[word_idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
      end
    end
  end

  assign ready_o = ready_s;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed self-checking bench: instance 0 uses LATENCY=1, instance 1 uses
// LATENCY=4. Inputs are driven on the falling edge, outputs sampled 1 ns
// after the rising edge.
module tb_data_mem_sized;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_s   [2];
  logic        rdy_s   [2];
  logic        we_s    [2];
  logic [1:0]  sz_s    [2];
  logic        uns_s   [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdat_s  [2];
  logic        vld_s   [2];
  logic        err_s   [2];
  logic [31:0] dout_s  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_sized #(
      .DEPTH_BYTES (32),
      .ADDR_W      (32),
      .LATENCY     ((g == 0) ? 1 : 4)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req_s[g]),
      .ready_o    (rdy_s[g]),
      .we_i       (we_s[g]),
      .size_i     (sz_s[g]),
      .unsigned_i (uns_s[g]),
      .addr_i     (addr_s[g]),
      .data_i     (wdat_s[g]),
      .valid_o    (vld_s[g]),
      .err_o      (err_s[g]),
      .data_o     (dout_s[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on instance d. lat = rising edges after the accept edge
  // until valid_o is seen (20 means it never came); rlow = samples with
  // ready_o low from the accept edge up to completion. With hold set, req_i
  // stays high during BUSY.
  task automatic xact(input int d, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input bit hold,
                      output int lat, output int rlow, output logic e, output logic [31:0] q);
    @(negedge clk);
    req_s[d] = 1'b1; we_s[d] = we; sz_s[d] = sz; uns_s[d] = uns;
    addr_s[d] = a; wdat_s[d] = wd;
    @(posedge clk); #1;
    // Scramble the fields after the accept edge; the DUT must use its capture.
    addr_s[d] = 32'h0000_0000; wdat_s[d] = 32'hDEAD_BEEF; sz_s[d] = 2'b00; uns_s[d] = ~uns;
    if (!hold) req_s[d] = 1'b0;
    lat = 0;
    rlow = rdy_s[d] ? 0 : 1;
    while (!vld_s[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!rdy_s[d]) rlow++;
    end
    req_s[d] = 1'b0;
    e = err_s[d];
    q = dout_s[d];
  endtask

  initial begin
    int lat, rlow, extra;
    logic e;
    logic [31:0] q;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; sz_s[i] = 2'b00; uns_s[i] = 1'b0;
      addr_s[i] = 32'h0; wdat_s[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl0", {29'd0, rdy_s[0], vld_s[0], err_s[0]}, 32'h0000_0004);
    chk("reset_dat0", dout_s[0], 32'h0000_0000);
    chk("reset_ctl1", {29'd0, rdy_s[1], vld_s[1], err_s[1]}, 32'h0000_0004);
    chk("reset_dat1", dout_s[1], 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    // ---- LATENCY = 1 ----
    xact(0, 1'b1, SZ_WORD, 1'b0, 32'd4, 32'h89AB_CDEF, 1'b0, lat, rlow, e, q);
    chk("sw4_lat", lat, 32'd1);
    chk("sw4_err", {31'd0, e}, 32'd0);
    chk("sw4_dout_held", q, 32'h0000_0000);
    xact(0, 1'b0, SZ_WORD, 1'b0, 32'd4, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lw4_lat", lat, 32'd1);
    chk("lw4_err", {31'd0, e}, 32'd0);
    chk("lw4_data", q, 32'h89AB_CDEF);
    xact(0, 1'b0, SZ_BYTE, 1'b0, 32'd7, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lb7_signed", q, 32'hFFFF_FF89);
    xact(0, 1'b0, SZ_BYTE, 1'b1, 32'd7, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lb7_unsigned", q, 32'h0000_0089);
    xact(0, 1'b0, SZ_HALF, 1'b0, 32'd6, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lh6_signed", q, 32'hFFFF_89AB);
    xact(0, 1'b0, SZ_HALF, 1'b1, 32'd6, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lh6_unsigned", q, 32'h0000_89AB);
    xact(0, 1'b0, SZ_BYTE, 1'b1, 32'd4, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lbu4", q, 32'h0000_00EF);
    xact(0, 1'b1, SZ_BYTE, 1'b0, 32'd5, 32'hAABB_CC55, 1'b0, lat, rlow, e, q);
    chk("sb5_dout_held", q, 32'h0000_00EF);
    xact(0, 1'b0, SZ_WORD, 1'b0, 32'd4, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lw4_after_sb", q, 32'h89AB_55EF);

    // Error cases
    xact(0, 1'b0, SZ_HALF, 1'b0, 32'd3, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lh3_err", {31'd0, e}, 32'd1);
    chk("lh3_lat", lat, 32'd1);
    chk("lh3_data", q, 32'h0000_0000);
    xact(0, 1'b0, SZ_WORD, 1'b0, 32'd30, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lw30_err", {31'd0, e}, 32'd1);
    xact(0, 1'b0, SZ_RSVD, 1'b0, 32'd4, 32'h0, 1'b0, lat, rlow, e, q);
    chk("rsvd_err", {31'd0, e}, 32'd1);
    chk("rsvd_data", q, 32'h0000_0000);
    xact(0, 1'b0, SZ_WORD, 1'b0, 32'd32, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lw32_err", {31'd0, e}, 32'd1);
    xact(0, 1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lw_top_err", {31'd0, e}, 32'd1);
    xact(0, 1'b1, SZ_HALF, 1'b0, 32'd5, 32'h0000_7777, 1'b0, lat, rlow, e, q);
    chk("sh5_err", {31'd0, e}, 32'd1);
    xact(0, 1'b1, SZ_RSVD, 1'b0, 32'd4, 32'h1111_1111, 1'b0, lat, rlow, e, q);
    chk("srsvd_err", {31'd0, e}, 32'd1);
    xact(0, 1'b0, SZ_WORD, 1'b0, 32'd4, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lw4_unchanged", q, 32'h89AB_55EF);
    chk("lw4_unchanged_err", {31'd0, e}, 32'd0);

    // Upper boundary: word at DEPTH-4 and byte at DEPTH-1 are legal
    xact(0, 1'b1, SZ_WORD, 1'b0, 32'd28, 32'h0102_0304, 1'b0, lat, rlow, e, q);
    chk("sw28_err", {31'd0, e}, 32'd0);
    xact(0, 1'b0, SZ_BYTE, 1'b0, 32'd31, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lb31_data", q, 32'h0000_0001);
    xact(0, 1'b0, SZ_BYTE, 1'b0, 32'd32, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lb32_err", {31'd0, e}, 32'd1);
    xact(0, 1'b0, SZ_HALF, 1'b0, 32'd30, 32'h0, 1'b0, lat, rlow, e, q);
    chk("lh30_data", q, 32'h0000_0102);

    // ---- LATENCY = 4 ----
    xact(1, 1'b1, SZ_WORD, 1'b0, 32'd8, 32'hCAFE_F00D, 1'b1, lat, rlow, e, q);
    chk("l4_sw8_lat", lat, 32'd4);
    chk("l4_sw8_rlow", rlow, 32'd4);
    chk("l4_sw8_err", {31'd0, e}, 32'd0);
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (vld_s[1]) extra++;
    end
    chk("l4_no_extra_accept", extra, 32'd0);
    xact(1, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0, 1'b0, lat, rlow, e, q);
    chk("l4_lw8_lat", lat, 32'd4);
    chk("l4_lw8_data", q, 32'hCAFE_F00D);

    // Reset lands on the access edge of a pending store
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b1; sz_s[1] = SZ_WORD; addr_s[1] = 32'd8; wdat_s[1] = 32'h1234_5678;
    @(posedge clk); #1;
    req_s[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", {31'd0, vld_s[1]}, 32'd0);
    chk("rst_mid_ready", {31'd0, rdy_s[1]}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_after_valid", {31'd0, vld_s[1]}, 32'd0);
    xact(1, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0, 1'b0, lat, rlow, e, q);
    chk("rst_lw8_lat", lat, 32'd4);
    chk("rst_lw8_data", q, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
